// File: rtl/fetch_pkg.sv
// Purpose: shared types and constants for the instruction-fetch sequencer.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package fetch_pkg;

    localparam int PC_W = 32;

    // Byte distance between consecutive instruction words
    localparam logic [PC_W-1:0] PC_INC = 32'd4;

    localparam logic [31:0] DEFAULT_RESET_PC  = 32'h0000_0000;
    localparam logic [31:0] DEFAULT_HALT_WORD = 32'h0000_000C;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_REQ    = 2'd1,
        ST_VALID  = 2'd2,
        ST_HALTED = 2'd3
    } fetch_state_e;

endpackage

// File: rtl/fetch_sequencer_next_pc_unit.sv
// Purpose: next-PC selection (jump > taken branch > sequential).
// Latency: purely combinational.
// Backpressure: none; the caller decides when the result is consumed.
//
// Ports: pc (current word address), jump/jump_target (J-type word index),
//        branch_taken/branch_offset (signed word offset), next_pc (result).
module next_pc_unit
    import fetch_pkg::*;
(
    input  logic [PC_W-1:0] pc,
    input  logic            jump,
    input  logic [25:0]     jump_target,
    input  logic            branch_taken,
    input  logic [15:0]     branch_offset,
    output logic [PC_W-1:0] next_pc
);

    logic [PC_W-1:0] pc4;
    logic [PC_W-1:0] branch_disp;

    // Arithmetic wraps modulo 2^32, so 0xFFFF_FFFC + 4 lands on 0.
    assign pc4         = pc + PC_INC;
    assign branch_disp = {{14{branch_offset[15]}}, branch_offset, 2'b00};

    always_comb begin
        next_pc = pc4;
        if (jump) begin
            // Jump stays inside the 256 MB region of the delay-slot address
            next_pc = {pc4[31:28], jump_target, 2'b00};
        end else if (branch_taken) begin
            next_pc = pc4 + branch_disp;
        end
    end

endmodule

// File: rtl/fetch_sequencer.sv
// Purpose: owns the PC, fetches words from instruction memory over req/ack, holds them for decode.
// Latency: 2 cycles per instruction with zero-wait memory; +1 per memory wait cycle, +1 per stall cycle.
// Backpressure: Stall holds the current instruction and PC; MemAck is the memory-side wait control.
//
// Ports: Clk, Reset (synchronous, active-high); Stall, BranchTaken/BranchOffset,
//        Jump/JumpTarget from decode; MemReq/MemAddr/MemAck/MemData to instruction
//        memory; Inst/InstValid/PCOut to decode; Halted status.
// Build option: define FETCH_HALT_EN to stop fetching after an instruction equal to HALT_WORD.
module fetch_sequencer
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC  = DEFAULT_RESET_PC,
    parameter logic [31:0] HALT_WORD = DEFAULT_HALT_WORD
)(
    input  logic        Clk,
    input  logic        Reset,
    input  logic        Stall,
    input  logic        BranchTaken,
    input  logic [15:0] BranchOffset,
    input  logic        Jump,
    input  logic [25:0] JumpTarget,
    input  logic        MemAck,
    input  logic [31:0] MemData,
    output logic        MemReq,
    output logic [31:0] MemAddr,
    output logic [31:0] Inst,
    output logic        InstValid,
    output logic [31:0] PCOut,
    output logic        Halted
);

    localparam logic [1:0] S_IDLE   = 2'(ST_IDLE);
    localparam logic [1:0] S_REQ    = 2'(ST_REQ);
    localparam logic [1:0] S_VALID  = 2'(ST_VALID);
    localparam logic [1:0] S_HALTED = 2'(ST_HALTED);

    // Instruction words are word aligned; low address bits are never honoured.
    localparam logic [31:0] RESET_PC_ALIGNED = {RESET_PC[31:2], 2'b00};

    logic [1:0]      state;
    logic [PC_W-1:0] pc;
    logic [PC_W-1:0] pc_nxt;
    logic            halt_hit;

    next_pc_unit u_next_pc (
        .pc            (pc),
        .jump          (Jump),
        .jump_target   (JumpTarget),
        .branch_taken  (BranchTaken),
        .branch_offset (BranchOffset),
        .next_pc       (pc_nxt)
    );

`ifdef FETCH_HALT_EN
    assign halt_hit = (Inst == HALT_WORD);
    assign Halted   = (state == S_HALTED);
`else
    logic halt_word_unused;
    assign halt_word_unused = ^HALT_WORD;
    assign halt_hit         = 1'b0;
    assign Halted           = 1'b0;
`endif

    // Outputs decode straight from flops: no input-to-output combinational path.
    assign MemReq    = (state == S_REQ);
    assign MemAddr   = pc;
    assign InstValid = (state == S_VALID);

    always_ff @(posedge Clk) begin
        if (Reset) begin
            // Also abandons any outstanding request; an ack on this edge is dropped.
            state <= S_IDLE;
            pc    <= RESET_PC_ALIGNED;
            Inst  <= '0;
            PCOut <= RESET_PC_ALIGNED;
        end else begin
            case (state)
                S_IDLE: state <= S_REQ;
                S_REQ: begin
                    if (MemAck) begin
                        Inst  <= MemData;
                        PCOut <= pc;
                        state <= S_VALID;
                    end
                end
                S_VALID: begin
                    // Redirect inputs only matter on the cycle decode accepts Inst.
                    if (!Stall) begin
                        if (halt_hit) begin
                            state <= S_HALTED;
                        end else begin
                            pc    <= pc_nxt;
                            state <= S_REQ;
                        end
                    end
                end
                default: ; // HALTED: everything frozen until Reset
            endcase
        end
    end

endmodule
